// File: rtl/except_commit_if.sv
// Commit-stage bundle between the pipeline and the exception/CP0 commit block.
// Covers the commit info, the MTC0/MFC0 port, the flush handshake and the live CP0 views.
interface except_commit_if;
    logic        valid_i;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [31:0] bad_vaddr_i;
    logic [5:0]  hw_int_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic        flush_ack_i;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;

    modport master (
        output valid_i, excepttype_i, pc_i, in_delayslot_i, bad_vaddr_i, hw_int_i,
        output we_i, waddr_i, wdata_i, raddr_i, flush_ack_i,
        input  rdata_o, flush_o, new_pc_o, status_o, cause_o, epc_o
    );

    modport slave (
        input  valid_i, excepttype_i, pc_i, in_delayslot_i, bad_vaddr_i, hw_int_i,
        input  we_i, waddr_i, wdata_i, raddr_i, flush_ack_i,
        output rdata_o, flush_o, new_pc_o, status_o, cause_o, epc_o
    );
endinterface

// File: rtl/except_commit.sv
// Commit-side exception/interrupt arbiter: updates Status/Cause/EPC/BadVAddr and
// redirects the pipeline through a flush/new-PC handshake held until acknowledged.
module except_commit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic           clk,
    input  logic           rst,
    except_commit_if.slave bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    logic [0:0]  state_reg;
    logic [5:0]  sync1_reg, sync2_reg;
    logic [7:0]  im_reg;
    logic        exl_reg, ie_reg;
    logic        bd_reg;
    logic [1:0]  ip_sw_reg;
    logic [4:0]  exc_code_reg;
    logic [31:0] epc_reg, badvaddr_reg, new_pc_reg;

    logic [31:0] status_val, cause_val;
    logic [7:0]  ip_all;
    logic        int_pend;
    logic        take_exc, take_eret, addr_fault;
    logic [4:0]  exc_code_next;

    assign ip_all     = {sync2_reg, ip_sw_reg};
    assign int_pend   = ie_reg & ~exl_reg & |(ip_all & im_reg);
    assign status_val = {9'b0, 1'b1, 6'b0, im_reg, 6'b0, exl_reg, ie_reg};
    assign cause_val  = {bd_reg, 15'b0, ip_all, 1'b0, exc_code_reg, 2'b0};

    // Priority arbitration; ERET only redirects when nothing above it fires.
    always_comb begin
        take_exc      = 1'b0;
        take_eret     = 1'b0;
        addr_fault    = 1'b0;
        exc_code_next = 5'd0;
        if (state_reg == ST_IDLE && bus.valid_i) begin
            take_exc = 1'b1;
            if (int_pend)                    exc_code_next = 5'd0;
            else if (bus.excepttype_i[4])  begin exc_code_next = 5'd4;  addr_fault = 1'b1; end
            else if (bus.excepttype_i[9])    exc_code_next = 5'd10;
            else if (bus.excepttype_i[12])   exc_code_next = 5'd12;
            else if (bus.excepttype_i[8])    exc_code_next = 5'd8;
            else if (bus.excepttype_i[10])   exc_code_next = 5'd9;
            else if (bus.excepttype_i[5])  begin exc_code_next = 5'd5;  addr_fault = 1'b1; end
            else begin
                take_exc  = 1'b0;
                take_eret = bus.excepttype_i[13];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            sync1_reg    <= 6'd0;
            sync2_reg    <= 6'd0;
            im_reg       <= 8'd0;
            exl_reg      <= 1'b0;
            ie_reg       <= 1'b0;
            bd_reg       <= 1'b0;
            ip_sw_reg    <= 2'd0;
            exc_code_reg <= 5'd0;
            epc_reg      <= 32'd0;
            badvaddr_reg <= 32'd0;
            new_pc_reg   <= 32'd0;
        end else begin
            sync1_reg <= bus.hw_int_i;
            sync2_reg <= sync1_reg;
            if (state_reg == ST_IDLE) begin
                if (take_exc) begin
                    state_reg    <= ST_FLUSH;
                    exc_code_reg <= exc_code_next;
                    exl_reg      <= 1'b1;
                    new_pc_reg   <= EXC_VECTOR;
                    // A nested exception keeps the original return point.
                    if (!exl_reg) begin
                        epc_reg <= bus.in_delayslot_i ? bus.pc_i - 32'd4 : bus.pc_i;
                        bd_reg  <= bus.in_delayslot_i;
                    end
                    if (addr_fault)
                        badvaddr_reg <= bus.bad_vaddr_i;
                end else if (take_eret) begin
                    state_reg  <= ST_FLUSH;
                    exl_reg    <= 1'b0;
                    new_pc_reg <= epc_reg;
                end else if (bus.we_i) begin
                    case (bus.waddr_i)
                        REG_STATUS: begin
                            im_reg  <= bus.wdata_i[15:8];
                            exl_reg <= bus.wdata_i[1];
                            ie_reg  <= bus.wdata_i[0];
                        end
                        REG_CAUSE: ip_sw_reg <= bus.wdata_i[9:8];
                        REG_EPC:   epc_reg   <= bus.wdata_i;
                        default: ;
                    endcase
                end
            end else if (bus.flush_ack_i) begin
                state_reg <= ST_IDLE;
            end
        end
    end

    always_comb begin
        case (bus.raddr_i)
            REG_BADVADDR: bus.rdata_o = badvaddr_reg;
            REG_STATUS:   bus.rdata_o = status_val;
            REG_CAUSE:    bus.rdata_o = cause_val;
            REG_EPC:      bus.rdata_o = epc_reg;
            default:      bus.rdata_o = 32'd0;
        endcase
    end

    assign bus.flush_o  = (state_reg == ST_FLUSH);
    assign bus.new_pc_o = new_pc_reg;
    assign bus.status_o = status_val;
    assign bus.cause_o  = cause_val;
    assign bus.epc_o    = epc_reg;
endmodule

// File: doc/except_commit.md
# except_commit

Commit-side consumer of the per-stage exception vectors: it takes the merged `excepttype` word at the MEM/commit stage, arbitrates it against pending hardware interrupts, and updates the exception CP0 registers (Status, Cause, EPC, BadVAddr). It redirects the pipeline with a flush/new-PC handshake, and it serves MTC0 writes and MFC0 reads for those registers.

## Interface
Parameters:
- `EXC_VECTOR`, default 32'hBFC00380: target PC for every exception and interrupt.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_i`  in  1  a committing instruction is present this cycle.
- `excepttype_i`  in  32  exception bits of the committing instruction:
  - [4] AdEL, [5] AdES, [8] Syscall, [9] RI, [10] Break, [12] Ov, [13] ERET.
  - All other bits are ignored.
- `pc_i`  in  32  PC of the committing instruction.
- `in_delayslot_i`  in  1  the committing instruction is in a branch delay slot.
- `bad_vaddr_i`  in  32  faulting address for AdEL/AdES.
- `hw_int_i`  in  6  asynchronous hardware interrupt lines.
- `we_i`  in  1  MTC0 write strobe.
- `waddr_i`  in  5  MTC0 register number.
- `wdata_i`  in  32  MTC0 write data.
- `raddr_i`  in  5  MFC0 register number.
- `rdata_o`  out  32  MFC0 read data (combinational).
- `flush_ack_i`  in  1  the pipeline has taken the redirect.
- `flush_o`  out  1  flush request, held until acknowledged.
- `new_pc_o`  out  32  redirect target; valid while `flush_o`=1.
- `status_o`, `cause_o`, `epc_o`  out  32  live register values.

## Operation
Registers:
- BadVAddr (8): read-only.
- Status (12):
  - Writable fields: IM[15:8], EXL[1], IE[0].
  - BEV[22] is read-only 1.
  - All other bits read 0.
- Cause (13):
  - BD[31]: hardware-written.
  - IP[15:10]: hardware-written from the synchronized `hw_int_i`.
  - IP[9:8]: software-writable.
  - ExcCode[6:2]: hardware-written.
- EPC (14): fully writable.
- Any other address reads 0; writes to it are dropped.

Interrupt:
- `int_pend` = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- An interrupt is taken only when `valid_i`=1.

Priority, for a cycle in IDLE with `valid_i`=1, highest first:
- Int (ExcCode 0), AdEL (4), RI (10), Ov (12), Syscall (8), Break (9), AdES (5), ERET.

Exception taken (any case except ERET):
- ExcCode written.
- EXL set to 1.
- `new_pc_o` = `EXC_VECTOR`.
- If EXL was 0 before the update:
  - If `in_delayslot_i`=1: EPC = `pc_i`-4 and BD=1.
  - Otherwise: EPC = `pc_i` and BD=0.
- If EXL was already 1, EPC and BD are unchanged.
- AdEL/AdES also load BadVAddr = `bad_vaddr_i`.

ERET:
- EXL cleared.
- `new_pc_o` = EPC. This uses the EPC value before any same-cycle write.

FSM, two states:
- IDLE:
  - An exception or ERET moves to FLUSH.
  - Otherwise MTC0 writes are applied.
- FLUSH:
  - `flush_o`=1.
  - `valid_i` and `we_i` are ignored.
  - `flush_ack_i`=1 at an edge returns to IDLE.

Conflict rule: a taken exception, interrupt or ERET in the same cycle as `we_i` wins, and the write is dropped.

Interrupt synchronization:
- `hw_int_i` passes through a 2-flop synchronizer into Cause.IP[15:10] every cycle.
- This includes FLUSH.

## Timing
Reset values:
- Status = 32'h00400000.
- Cause, EPC, BadVAddr = 0.
- `flush_o`=0 and `new_pc_o`=0.
- FSM in IDLE.
- Synchronizer flops = 0.

Latency and handshake:
- Exception sampled at edge N means:
  - Register updates, `flush_o`=1 and `new_pc_o` are visible in cycle N+1.
- `flush_o` and `new_pc_o` stay stable until the edge where `flush_ack_i`=1.
- `flush_o`=0 the following cycle.
- An ack in the first FLUSH cycle gives a minimum of one flush cycle.
- A new exception is accepted the cycle after the return to IDLE.

Other timing:
- MTC0 write visible on `rdata_o` and the live outputs from the next cycle.
- `hw_int_i` to Cause.IP latency: 2 edges. `int_pend` can act on the third cycle.
- Async `rst` during FLUSH: `flush_o` drops immediately and all state returns to reset values.

## Test plan
- Syscall:
  - Stimulus: `valid_i`=1, `excepttype_i`=32'h100, `pc_i`=32'h80001000, EXL=0.
  - Next cycle: `flush_o`=1, `new_pc_o`=32'hBFC00380, EPC=32'h80001000, ExcCode=8, EXL=1.
  - `flush_o` held 3 cycles with ack low, drops the cycle after ack.
- Delay slot plus nested exception:
  - Ov with `in_delayslot_i`=1, `pc_i`=32'h80002004 → EPC=32'h80002000, BD=1.
  - A second RI while EXL=1 → EPC and BD unchanged, ExcCode=10.
- ERET:
  - Stimulus: EPC=32'h80003000, EXL=1, `excepttype_i`=32'h2000.
  - Response: `new_pc_o`=32'h80003000, EXL=0.
  - Same-cycle MTC0 to EPC is dropped.
- Interrupt:
  - Setup: IE=1, IM[10]=1, `hw_int_i`[0] raised.
  - Cause.IP[10]=1 after 2 edges.
  - Next `valid_i` together with `excepttype_i`=32'h1000 → ExcCode=0 (interrupt wins over Ov).
- AdEL and AdES together:
  - Stimulus: `excepttype_i`=32'h30, `bad_vaddr_i`=32'h80000003.
  - Response: ExcCode=4, BadVAddr=32'h80000003.
- Reset during FLUSH:
  - Assert `rst` mid-FLUSH → `flush_o`=0 immediately, Status=32'h00400000, all other registers 0.
